maze_path_player: RTL

//   Records the solver's move-direction stack as the solver pushes and pops it.
//   On request it replays the recorded path in order, from the maze start to the goal.

---
 rtl/maze_path_player_if.sv | 26 ++
 rtl/maze_path_player.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/maze_path_player_if.sv
// rtl/maze_path_player_if.sv - record/replay bus between the maze solver and the path player
// The solver side uses master; the player uses slave.
interface maze_path_player_if;
  logic       push;
  logic       pop;
  logic [1:0] dirIn;
  logic       run;
  logic       ready;
  logic       valid;
  logic [1:0] dirOut;
  logic [7:0] locOut;
  logic       last;
  logic       busy;
  logic       empty;
  logic       overflow;

  modport master (
    output push, pop, dirIn, run, ready,
    input  valid, dirOut, locOut, last, busy, empty, overflow
  );

  modport slave (
    input  push, pop, dirIn, run, ready,
    output valid, dirOut, locOut, last, busy, empty, overflow
  );
endinterface

// File: rtl/maze_path_player.sv
// rtl/maze_path_player.sv - records the solver's move stack and replays it as a valid/ready stream
// Replay walks the stack bottom-up, emitting each direction with the cell it leads to.
module maze_path_player #(
  parameter int         DEPTH     = 256,
  parameter int         AW        = 8,
  parameter logic [7:0] START_LOC = 8'h00
) (
  input logic               clk,
  input logic               rst,
  maze_path_player_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REPLAY = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

  state_e          state_q, state_d;
  logic [AW:0]     sp_q, sp_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [7:0]      loc_q, loc_d;
  logic            overflow_q, overflow_d;

  logic [1:0]      mem_q [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [1:0]      mem_wdata;

  logic [AW:0]     sp_m1;
  logic [1:0]      rd_dir;
  logic [7:0]      step_loc;
  logic            is_last;
  logic            beat_fire;

  // Rows and columns wrap modulo 16; the maze edge is not a bound here.
  function automatic logic [7:0] step(input logic [7:0] loc, input logic [1:0] dir);
    logic [3:0] row;
    logic [3:0] col;
    row = loc[7:4];
    col = loc[3:0];
    case (dir)
      2'b00:   row = row - 4'd1;
      2'b01:   col = col + 4'd1;
      2'b10:   col = col - 4'd1;
      default: row = row + 4'd1;
    endcase
    return {row, col};
  endfunction

  assign sp_m1     = sp_q - SP_ONE;
  assign rd_dir    = mem_q[idx_q];
  assign step_loc  = step(loc_q, rd_dir);
  assign is_last   = ({1'b0, idx_q} == sp_m1);
  assign beat_fire = (state_q == S_REPLAY) && bus.ready;

  // Stack recording is only live in IDLE so a replay always sees a frozen path.
  always_comb begin
    sp_d       = sp_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_waddr  = sp_q[AW-1:0];
    mem_wdata  = bus.dirIn;
    if (state_q == S_IDLE) begin
      if (bus.push && bus.pop && (sp_q != '0)) begin
        mem_we    = 1'b1;
        mem_waddr = sp_m1[AW-1:0];
      end else if (bus.push) begin
        if (sp_q == SP_FULL) begin
          overflow_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          sp_d   = sp_q + SP_ONE;
        end
      end else if (bus.pop && (sp_q != '0)) begin
        sp_d = sp_m1;
      end
    end
  end

  always_comb begin
    idx_d = idx_q;
    loc_d = loc_q;
    if (state_q == S_IDLE) begin
      idx_d = '0;
      loc_d = START_LOC;
    end else if (beat_fire) begin
      idx_d = idx_q + 1'b1;
      loc_d = step_loc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // sp_d is used so a push landing with run on an empty stack still starts a replay.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.run && (sp_d != '0)) state_d = S_REPLAY;
      S_REPLAY: if (beat_fire && is_last)    state_d = S_DONE;
      S_DONE:   if (!bus.run)                state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.valid    = 1'b0;
    bus.dirOut   = 2'b00;
    bus.locOut   = START_LOC;
    bus.last     = 1'b0;
    bus.busy     = (state_q != S_IDLE);
    bus.empty    = (sp_q == '0);
    bus.overflow = overflow_q;
    if (state_q == S_REPLAY) begin
      bus.valid  = 1'b1;
      bus.dirOut = rd_dir;
      bus.locOut = step_loc;
      bus.last   = is_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q       <= '0;
      idx_q      <= '0;
      loc_q      <= START_LOC;
      overflow_q <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      idx_q      <= idx_d;
      loc_q      <= loc_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule
